// File: rtl/output_unit_fifo.sv
// Buffered CU output unit: 4-phase out_req/out_ack push side, FWFT valid/ready drain side.
// Optional OUT_STATS_EN enables the stat_count / stat_stall counters (tied to 0 otherwise).
module output_unit_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          out_req,
    input  logic [DW-1:0] out_data,
    input  logic [1:0]    out_fmt,
    output logic          out_ack,
    output logic          dev_valid,
    output logic [DW-1:0] dev_data,
    output logic [1:0]    dev_fmt,
    input  logic          dev_ready,
    output logic [AW:0]   fifo_level,
    output logic          full,
    output logic          empty,
    output logic [31:0]   stat_count,
    output logic [15:0]   stat_stall
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } cu_state_t;

    cu_state_t state_reg;
    cu_state_t state_next;

    logic [DW+1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic [DW+1:0] head;
    logic          push;
    logic          pop;

    assign full       = (level_reg == (AW+1)'(DEPTH));
    assign empty      = (level_reg == '0);
    assign fifo_level = level_reg;
    assign out_ack    = (state_reg == ACK);

    assign head      = mem[rd_ptr_reg];
    assign dev_valid = !empty;
    assign dev_data  = head[DW+1:2];
    assign dev_fmt   = head[1:0];

    // Push is gated by the pre-edge full flag, so a simultaneous pop cannot unblock it.
    assign pop = dev_valid && dev_ready;

    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (out_req && !full) begin
                    push       = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!out_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Storage is left unreset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {out_data, out_fmt};
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + (AW+1)'(1);
                2'b01:   level_reg <= level_reg - (AW+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

`ifdef OUT_STATS_EN
    logic [31:0] stat_count_reg;
    logic [15:0] stat_stall_reg;
    logic        stall;

    assign stall = (state_reg == IDLE) && out_req && full;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stat_count_reg <= '0;
            stat_stall_reg <= '0;
        end else begin
            if (pop) begin
                stat_count_reg <= stat_count_reg + 32'd1;
            end
            if (stall && (stat_stall_reg != 16'hFFFF)) begin
                stat_stall_reg <= stat_stall_reg + 16'd1;
            end
        end
    end

    assign stat_count = stat_count_reg;
    assign stat_stall = stat_stall_reg;
`else
    assign stat_count = '0;
    assign stat_stall = '0;
`endif

`ifndef SYNTHESIS
    // Console echo of every popped word in its requested format.
    always @(posedge clk) begin
        if (rst_b && pop) begin
            case (dev_fmt)
                2'd0:    $display("[OUTPUT_UNIT] OUT> %0d", dev_data);
                2'd1:    $display("[OUTPUT_UNIT] OUT> %0d", $signed(dev_data));
                2'd2:    $display("[OUTPUT_UNIT] OUT> 0x%h", dev_data);
                default: $display("[OUTPUT_UNIT] OUT> 0b%b", dev_data);
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_output_unit_fifo.sv
// Scoreboard bench for output_unit_fifo: randomized CU pushes and device back-pressure,
// checked against a queue/counter reference model sampled on the falling edge.
module tb_output_unit_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          out_req = 1'b0;
    logic [DW-1:0] out_data = '0;
    logic [1:0]    out_fmt = '0;
    logic          out_ack;
    logic          dev_valid;
    logic [DW-1:0] dev_data;
    logic [1:0]    dev_fmt;
    logic          dev_ready = 1'b0;
    logic [AW:0]   fifo_level;
    logic          full;
    logic          empty;
    logic [31:0]   stat_count;
    logic [15:0]   stat_stall;

    output_unit_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .out_req    (out_req),
        .out_data   (out_data),
        .out_fmt    (out_fmt),
        .out_ack    (out_ack),
        .dev_valid  (dev_valid),
        .dev_data   (dev_data),
        .dev_fmt    (dev_fmt),
        .dev_ready  (dev_ready),
        .fifo_level (fifo_level),
        .full       (full),
        .empty      (empty),
        .stat_count (stat_count),
        .stat_stall (stat_stall)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [DW+1:0] exp_q [$];
    int ready_mode = 0;   // 0 low, 1 high, 2 random
    bit fill_done = 0;

    // Reference model state
    int          m_level = 0;
    bit          m_ack = 0;
    logic [31:0] m_pops = 0;
    int          m_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       dev_ready = 1'b0;
            1:       dev_ready = 1'b1;
            default: dev_ready = ($urandom_range(0, 99) < 45);
        endcase
    end

    // Monitor: compare DUT against the model, pop the scoreboard, then advance the model.
    always @(negedge clk) begin
        if (!rst_b) begin
            m_level = 0;
            m_ack   = 0;
            m_pops  = 0;
            m_stall = 0;
        end else begin
            bit do_push;
            bit do_pop;
            check("out_ack", {31'd0, out_ack}, {31'd0, m_ack});
            check("fifo_level", 32'(fifo_level), 32'(m_level));
            check("full", {31'd0, full}, {31'd0, m_level == DEPTH});
            check("empty", {31'd0, empty}, {31'd0, m_level == 0});
            check("dev_valid", {31'd0, dev_valid}, {31'd0, m_level != 0});
`ifdef OUT_STATS_EN
            check("stat_count", stat_count, m_pops);
            check("stat_stall", {16'd0, stat_stall}, 32'(m_stall));
`else
            check("stat_count", stat_count, 32'd0);
            check("stat_stall", {16'd0, stat_stall}, 32'd0);
`endif
            if (dev_valid && dev_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no word", dev_data);
                end else begin
                    logic [DW+1:0] e;
                    e = exp_q.pop_front();
                    check("dev_data", 32'(dev_data), 32'(e[DW+1:2]));
                    check("dev_fmt", 32'(dev_fmt), 32'(e[1:0]));
                end
            end
            do_push = !m_ack && out_req && (m_level < DEPTH);
            do_pop  = (m_level > 0) && dev_ready;
            if (!m_ack && out_req && (m_level == DEPTH) && m_stall < 16'hFFFF) m_stall++;
            if (do_pop) m_pops = m_pops + 32'd1;
            m_level = m_level + int'(do_push) - int'(do_pop);
            if (do_push) m_ack = 1;
            else if (m_ack && !out_req) m_ack = 0;
        end
    end

    task automatic push_word(input logic [DW-1:0] d, input logic [1:0] f);
        int n;
        exp_q.push_back({d, f});
        out_data = d;
        out_fmt  = f;
        out_req  = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_ack && n < 500);
        if (!out_ack) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ack_timeout: got out_ack=0, expected 1 within 500 cycles");
        end
        out_req = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (out_ack && n < 500);
        out_data = DW'($urandom);
    endtask

    task automatic wait_drained();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !empty) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, out_ack}, 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_valid", {31'd0, dev_valid}, 32'd0);
        check("rst_stats", stat_count | {16'd0, stat_stall}, 32'd0);
        #2 rst_b = 1'b1;

        // Single push and format variety
        ready_mode = 1;
        @(posedge clk); #1;
        push_word(16'd42, 2'd0);
        push_word(16'hFFFE, 2'd1);
        push_word(16'hFFFE, 2'd2);
        push_word(16'hFFFE, 2'd3);
        wait_drained();

        // Fill with device stalled; fifth push must stall until a pop frees space
        ready_mode = 0;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 5; i++) push_word(DW'(16'h100 + i), 2'(i));
                fill_done = 1;
            end
        join_none
        repeat (25) @(posedge clk);
        #1;
        check("fill_level", 32'(fifo_level), 32'(DEPTH));
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_ack_blocked", {31'd0, out_ack}, 32'd0);
        ready_mode = 1;
        for (int n = 0; n < 500 && !fill_done; n++) begin
            @(posedge clk); #1;
        end
        check("fill_done", {31'd0, fill_done}, 32'd1);
        wait_drained();

        // Randomized traffic with random back-pressure
        ready_mode = 2;
        for (int i = 0; i < 150; i++) begin
            push_word(DW'($urandom), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        ready_mode = 1;
        wait_drained();

        // Reset while a handshake is in ACK with three words buffered
        ready_mode = 0;
        @(posedge clk); #1;
        push_word(16'h0AAA, 2'd2);
        push_word(16'h0BBB, 2'd2);
        exp_q.push_back({16'h0CCC, 2'd2});
        out_data = 16'h0CCC;
        out_fmt  = 2'd2;
        out_req  = 1'b1;
        for (int n = 0; n < 50 && !out_ack; n++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_level", 32'(fifo_level), 32'd3);
        #2 rst_b = 1'b0;
        #1;
        check("midrst_ack", {31'd0, out_ack}, 32'd0);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_valid", {31'd0, dev_valid}, 32'd0);
        check("midrst_empty", {31'd0, empty}, 32'd1);
        out_req = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_b = 1'b1;

        // Post-reset sanity
        ready_mode = 2;
        for (int i = 0; i < 20; i++) push_word(DW'($urandom), 2'($urandom_range(0, 3)));
        ready_mode = 1;
        wait_drained();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
